uart_alu_ctrl: RTL and testbench

Sequencing controller between the UART receiver, the ALU and the UART transmitter. Collects three received bytes (operand A, operand B, opcode), presents them to the combinational ALU, then hands the ALU result to the transmitter and waits for its completion before accepting a new frame. It is the only block that drives the ALU inputs and the transmitter start strobe.

---
 rtl/uart_alu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects A, B and opcode bytes from the UART receiver,
// presents them to the ALU, then sends the ALU result through the transmitter.
// The optional inter-byte timeout is enabled with macro UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned NB_TIMEOUT     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_frame_error
);

    // Reject parameter sets the timeout counter cannot represent.
    if ((TIMEOUT_CYCLES < 2) || (64'(TIMEOUT_CYCLES) >= (64'd1 << NB_TIMEOUT))) begin : g_bad_cfg
        $error("uart_alu_ctrl: TIMEOUT_CYCLES must be >= 2 and < 2**NB_TIMEOUT");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NB_DATA-1:0] data_a_next;
    logic [NB_DATA-1:0] data_b_next;
    logic [NB_OP-1:0]   op_next;
    logic [NB_DATA-1:0] tx_data_next;
    logic               tx_start_next;
    logic               busy_next;
    logic               frame_error_next;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    logic [NB_TIMEOUT-1:0] cnt;
    logic [NB_TIMEOUT-1:0] cnt_next;
    logic                  timeout_hit;

    // Last idle cycle allowed before the partial frame is abandoned.
    assign timeout_hit = (cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and next-output decode; registers hold unless a byte is captured.
    always_comb begin
        state_next       = state;
        data_a_next      = o_data_a;
        data_b_next      = o_data_b;
        op_next          = o_op;
        tx_data_next     = o_tx_data;
        tx_start_next    = 1'b0;
        frame_error_next = 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        cnt_next         = '0;
`endif

        case (state)
            ST_IDLE: begin
                if (i_rx_done_tick) begin
                    data_a_next = i_rx_data;
                    state_next  = ST_WAIT_B;
                end
            end

            ST_WAIT_B: begin
                if (i_rx_done_tick) begin
                    data_b_next = i_rx_data;
                    state_next  = ST_WAIT_OP;
                end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next       = ST_IDLE;
                    frame_error_next = 1'b1;
                end else begin
                    cnt_next = cnt + NB_TIMEOUT'(1);
                end
`endif
            end

            ST_WAIT_OP: begin
                if (i_rx_done_tick) begin
                    op_next    = i_rx_data[NB_OP-1:0];
                    state_next = ST_EXEC;
                end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next       = ST_IDLE;
                    frame_error_next = 1'b1;
                end else begin
                    cnt_next = cnt + NB_TIMEOUT'(1);
                end
`endif
            end

            ST_EXEC: begin
                tx_data_next  = i_alu_result;
                tx_start_next = 1'b1;
                state_next    = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (i_tx_done_tick) begin
                    if (i_rx_done_tick) begin
                        // Next frame's first byte arrived with the transmit completion.
                        data_a_next = i_rx_data;
                        state_next  = ST_WAIT_B;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_EXEC) || (state_next == ST_WAIT_TX);
    end

    // State and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            o_data_a      <= '0;
            o_data_b      <= '0;
            o_op          <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            state         <= state_next;
            o_data_a      <= data_a_next;
            o_data_b      <= data_b_next;
            o_op          <= op_next;
            o_tx_data     <= tx_data_next;
            o_tx_start    <= tx_start_next;
            o_busy        <= busy_next;
            o_frame_error <= frame_error_next;
        end
    end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // Inter-byte idle counter.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed vector table, hand-written
// corner sequences and randomized frames against a frame-level model.
module tb_uart_alu_ctrl;

    localparam int unsigned NB_DATA    = 8;
    localparam int unsigned NB_OP      = 6;
    localparam int unsigned NB_TIMEOUT = 20;
    localparam int unsigned TCYC       = 100;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_rx_done_tick;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done_tick;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_frame_error;

    int n_tests    = 0;
    int n_fail     = 0;
    int err_pulses = 0;

    uart_alu_ctrl #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TCYC)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx_done_tick (i_rx_done_tick),
        .i_rx_data      (i_rx_data),
        .i_alu_result   (i_alu_result),
        .i_tx_done_tick (i_tx_done_tick),
        .o_data_a       (o_data_a),
        .o_data_b       (o_data_b),
        .o_op           (o_op),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_busy         (o_busy),
        .o_frame_error  (o_frame_error)
    );

    always #5 i_clock = ~i_clock;

    // Behavioural ALU seen by the controller.
    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return 8'(a + b);
            6'h22:   return 8'(a - b);
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return 8'($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb i_alu_result = alu(o_data_a, o_data_b, o_op);

    always @(negedge i_clock) if (o_frame_error === 1'b1) err_pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        tick();
        i_rx_done_tick = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"},     32'(o_data_a), 0);
        chk({tag, "_b"},     32'(o_data_b), 0);
        chk({tag, "_op"},    32'(o_op), 0);
        chk({tag, "_tx"},    32'(o_tx_data), 0);
        chk({tag, "_start"}, 32'(o_tx_start), 0);
        chk({tag, "_busy"},  32'(o_busy), 0);
        chk({tag, "_ferr"},  32'(o_frame_error), 0);
    endtask

    // Operand A already captured: send B and opcode, check the execute/transmit handshake.
    task automatic send_rest(input logic [7:0] b, input logic [7:0] opb, input int delay, input bit junk,
                             input logic [7:0] ea, input logic [7:0] eb, input logic [5:0] eop,
                             input logic [7:0] etx);
        send_byte(b);
        chk("b_busy", 32'(o_busy), 0);
        chk("b_ferr", 32'(o_frame_error), 0);
        send_byte(opb);
        chk("op_a", 32'(o_data_a), 32'(ea));
        chk("op_b", 32'(o_data_b), 32'(eb));
        chk("op_op", 32'(o_op), 32'(eop));
        chk("op_busy", 32'(o_busy), 1);
        chk("op_nostart", 32'(o_tx_start), 0);
        tick();
        chk("exec_start", 32'(o_tx_start), 1);
        chk("exec_tx", 32'(o_tx_data), 32'(etx));
        chk("exec_busy", 32'(o_busy), 1);
        tick();
        chk("wtx_start", 32'(o_tx_start), 0);
        chk("wtx_busy", 32'(o_busy), 1);
        for (int i = 0; i < delay; i++) begin
            if (junk && i == 0) begin
                i_rx_data      = 8'($urandom);
                i_rx_done_tick = 1'b1;
            end
            tick();
            i_rx_done_tick = 1'b0;
        end
        chk("wtx_hold_busy", 32'(o_busy), 1);
        i_tx_done_tick = 1'b1;
        tick();
        i_tx_done_tick = 1'b0;
        chk("done_busy", 32'(o_busy), 0);
        chk("done_start", 32'(o_tx_start), 0);
        chk("done_a_kept", 32'(o_data_a), 32'(ea));
        chk("done_tx_kept", 32'(o_tx_data), 32'(etx));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        bit         junk;
        logic [5:0] eop;
        logic [7:0] etx;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [5:0] ops[8];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] ropb;
        bit         early;

        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

        vecs.push_back('{8'h05, 8'h03, 8'h20, 1'b0, 6'h20, 8'h08});
        vecs.push_back('{8'h10, 8'h03, 8'hE2, 1'b0, 6'h22, 8'h0D});
        vecs.push_back('{8'hF0, 8'h0F, 8'h24, 1'b0, 6'h24, 8'h00});
        vecs.push_back('{8'hF0, 8'h0F, 8'h25, 1'b0, 6'h25, 8'hFF});
        vecs.push_back('{8'hAA, 8'h0F, 8'h26, 1'b0, 6'h26, 8'hA5});
        vecs.push_back('{8'h0F, 8'hF0, 8'h27, 1'b0, 6'h27, 8'h00});
        vecs.push_back('{8'h80, 8'h02, 8'h02, 1'b0, 6'h02, 8'h20});
        vecs.push_back('{8'h80, 8'h02, 8'hC3, 1'b0, 6'h03, 8'hE0});
        vecs.push_back('{8'hFF, 8'h01, 8'h20, 1'b1, 6'h20, 8'h00});
        vecs.push_back('{8'h01, 8'h01, 8'h20, 1'b0, 6'h20, 8'h02});

        i_reset        = 1'b1;
        i_rx_done_tick = 1'b0;
        i_rx_data      = 8'h00;
        i_tx_done_tick = 1'b0;
        #1;
        chk_all_zero("rst");
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        tick();
        chk_all_zero("post_rst");

        // Directed vector table; junk entries strobe a byte during WAIT_TX.
        foreach (vecs[i]) begin
            send_byte(vecs[i].a);
            send_rest(vecs[i].b, vecs[i].opb, 3, vecs[i].junk,
                      vecs[i].a, vecs[i].b, vecs[i].eop, vecs[i].etx);
        end

        // Receive strobe coincident with transmit completion starts a new frame.
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h20);
        tick();
        tick();
        i_rx_data      = 8'h0A;
        i_rx_done_tick = 1'b1;
        i_tx_done_tick = 1'b1;
        tick();
        i_rx_done_tick = 1'b0;
        i_tx_done_tick = 1'b0;
        chk("coin_a", 32'(o_data_a), 32'h0A);
        chk("coin_busy", 32'(o_busy), 0);
        chk("coin_start", 32'(o_tx_start), 0);
        tick();
        chk("coin_start2", 32'(o_tx_start), 0);
        send_rest(8'h03, 8'h20, 2, 1'b0, 8'h0A, 8'h03, 6'h20, 8'h0D);

        // Stray transmit completion in IDLE is ignored.
        i_tx_done_tick = 1'b1;
        tick();
        i_tx_done_tick = 1'b0;
        chk("stray_txdone_busy", 32'(o_busy), 0);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // Timeout after A: error pulse on the TCYC-th idle edge.
        send_byte(8'h05);
        early = 1'b0;
        for (int i = 1; i < int'(TCYC); i++) begin
            tick();
            early = early | o_frame_error;
        end
        chk("to_no_early_err", 32'(early), 0);
        tick();
        chk("to_err_pulse", 32'(o_frame_error), 1);
        chk("to_err_busy", 32'(o_busy), 0);
        tick();
        chk("to_err_clear", 32'(o_frame_error), 0);
        chk("to_stale_a", 32'(o_data_a), 32'h05);
        send_byte(8'h01);
        send_rest(8'h01, 8'h20, 1, 1'b0, 8'h01, 8'h01, 6'h20, 8'h02);
        // Strobe on the expiry cycle is captured.
        send_byte(8'h05);
        repeat (TCYC - 1) tick();
        send_rest(8'h07, 8'h20, 1, 1'b0, 8'h05, 8'h07, 6'h20, 8'h0C);
`else
        // Without the timeout, WAIT_B waits indefinitely.
        send_byte(8'h05);
        early = 1'b0;
        for (int i = 0; i < int'(TCYC) + 50; i++) begin
            tick();
            early = early | o_frame_error;
        end
        chk("noto_no_err", 32'(early), 0);
        send_rest(8'h07, 8'h20, 1, 1'b0, 8'h05, 8'h07, 6'h20, 8'h0C);
`endif

        // Async reset in WAIT_OP discards the partial frame.
        send_byte(8'h33);
        send_byte(8'h44);
        #2 i_reset = 1'b1;
        #1 chk_all_zero("rst_wop");
        @(negedge i_clock);
        i_reset = 1'b0;
        tick();
        chk("rst_wop_busy", 32'(o_busy), 0);
        send_byte(8'h06);
        send_rest(8'h07, 8'h20, 1, 1'b0, 8'h06, 8'h07, 6'h20, 8'h0D);

        // Async reset during the transmit start cycle.
        send_byte(8'h09);
        send_byte(8'h01);
        send_byte(8'h22);
        tick();
        chk("rst_tx_pre_start", 32'(o_tx_start), 1);
        #2 i_reset = 1'b1;
        #1 chk_all_zero("rst_tx");
        @(negedge i_clock);
        i_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_tx_no_start", 32'(o_tx_start), 0);
        end

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 150; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            ropb = {2'($urandom), ops[$urandom_range(0, 7)]};
            if ($urandom_range(0, 3) == 0) begin
                i_tx_done_tick = 1'b1;
                tick();
                i_tx_done_tick = 1'b0;
            end
            send_byte(ra);
            repeat ($urandom_range(0, 3)) tick();
            send_rest(rb, ropb, int'($urandom_range(0, 5)), 1'($urandom),
                      ra, rb, ropb[5:0], alu(ra, rb, ropb[5:0]));
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        chk("total_err_pulses", 32'(err_pulses), 1);
`else
        chk("total_err_pulses", 32'(err_pulses), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
